// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared types, limits and width helper for the priority encoder
package prio_enc_pkg;

   // Widest request vector the encoder is sized for.
   localparam int MAX_N = 64;

   // Search direction for fixed-priority encoding.
   typedef enum logic {
      LSB_FIRST = 1'b0,
      MSB_FIRST = 1'b1
   } dir_e;

   // ceil(log2(n)), never below 1 so a 2-input encoder still has a 1-bit code.
   function automatic int clog2_safe(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// rtl/prio_enc_comb.sv - combinational priority encoder with rotatable start index
module prio_enc_comb
   import prio_enc_pkg::*;
#(
   parameter int   N   = 8,
   parameter dir_e DIR = LSB_FIRST,
   localparam int  W   = clog2_safe(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] offset,
   output logic [W-1:0] code,
   output logic         any,
   output logic         multi
);

   // Walk the sources in priority order; first set bit wins.
   // LSB_FIRST searches upward from offset modulo N, MSB_FIRST searches down from N-1.
   always_comb begin
      logic         found;
      logic [W:0]   sum;
      logic [W-1:0] idx;
      code  = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (DIR == MSB_FIRST) begin
            idx = W'(N - 1 - i);
         end else begin
            sum = {1'b0, offset} + (W+1)'(i);
            if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
            idx = sum[W-1:0];
         end
         if (!found && req[idx]) begin
            code  = idx;
            found = 1'b1;
         end
      end
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   always_comb begin
      any   = |req;
      multi = |(req & (req - N'(1)));
   end

endmodule

// File: rtl/prio_encoder_reg.sv
// rtl/prio_encoder_reg.sv - registered N-input priority encoder with valid/ready handshake (option: PRIO_ENC_ROUND_ROBIN_EN)
module prio_encoder_reg #(
   parameter int  N         = 8,
   parameter int  MSB_FIRST = 0,
   localparam int W         = prio_enc_pkg::clog2_safe(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] req,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] code,
   output logic         any,
   output logic         multi,
   output logic         err_sticky
);

`ifdef PRIO_ENC_ROUND_ROBIN_EN
   // Rotating priority always searches upward from the pointer.
   localparam prio_enc_pkg::dir_e DIR = prio_enc_pkg::LSB_FIRST;
`else
   localparam prio_enc_pkg::dir_e DIR = (MSB_FIRST != 0) ? prio_enc_pkg::MSB_FIRST
                                                         : prio_enc_pkg::LSB_FIRST;
`endif

   logic         accept;
   logic [W-1:0] offset;
   logic [W-1:0] c_code;
   logic         c_any;
   logic         c_multi;

   // The output slot frees up in the same cycle it is drained.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   prio_enc_comb #(
      .N   (N),
      .DIR (DIR)
   ) u_comb (
      .req    (req),
      .offset (offset),
      .code   (c_code),
      .any    (c_any),
      .multi  (c_multi)
   );

`ifdef PRIO_ENC_ROUND_ROBIN_EN
   logic [W-1:0] ptr;

   assign offset = ptr;

   // Advance the pointer past the last winner; zero-hot vectors leave it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (accept && c_any) begin
         ptr <= (c_code == W'(N - 1)) ? '0 : c_code + W'(1);
      end
   end
`else
   assign offset = '0;
`endif

   // One-entry output register: load on accept, drop valid on drain, hold under stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         code       <= '0;
         any        <= 1'b0;
         multi      <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            code      <= c_code;
            any       <= c_any;
            multi     <= c_multi;
            if (c_multi) err_sticky <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prio_encoder_reg.sv
// tb/tb_prio_encoder_reg.sv - directed self-checking bench for prio_encoder_reg
module tb_prio_encoder_reg;

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;

   // u_lsb: N=8, lowest index wins
   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0] a_req;
   logic [2:0] a_code;
   logic       a_any, a_multi, a_err;

   // u_msb: N=8, highest index wins
   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0] b_req;
   logic [2:0] b_code;
   logic       b_any, b_multi, b_err;

   // u_n2: N=2 boundary
   logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
   logic [1:0] c_req;
   logic [0:0] c_code;
   logic       c_any, c_multi, c_err;

   prio_encoder_reg #(.N(8), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .req(a_req),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .code(a_code), .any(a_any),
      .multi(a_multi), .err_sticky(a_err));

   prio_encoder_reg #(.N(8), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .req(b_req),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .code(b_code), .any(b_any),
      .multi(b_multi), .err_sticky(b_err));

   prio_encoder_reg #(.N(2), .MSB_FIRST(0)) u_n2 (
      .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .req(c_req),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .code(c_code), .any(c_any),
      .multi(c_multi), .err_sticky(c_err));

`ifdef PRIO_ENC_ROUND_ROBIN_EN
   // u_rr: N=4 rotating priority
   logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [3:0] d_req;
   logic [1:0] d_code;
   logic       d_any, d_multi, d_err;

   prio_encoder_reg #(.N(4), .MSB_FIRST(0)) u_rr (
      .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .req(d_req),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .code(d_code), .any(d_any),
      .multi(d_multi), .err_sticky(d_err));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", a_out_valid); else pass_cnt++;
      total_cnt++; if (a_code !== 3'd0) $display("FAIL reset_code got=%0d exp=0", a_code); else pass_cnt++;
      total_cnt++; if (a_any !== 1'b0 || a_multi !== 1'b0) $display("FAIL reset_flags got any=%0b multi=%0b exp 0/0", a_any, a_multi); else pass_cnt++;
      total_cnt++; if (a_err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", a_err); else pass_cnt++;
      total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", a_in_ready); else pass_cnt++;
      step();
      rst = 1'b0;
      step();
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_req       = 8'b0010_1000;
      step();
      a_in_valid  = 1'b0;
      total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL mid_out_valid got=%0b exp=1", a_out_valid); else pass_cnt++;
      total_cnt++; if (a_code !== 3'd3) $display("FAIL mid_code got=%0d exp=3", a_code); else pass_cnt++;
      total_cnt++; if (a_any !== 1'b1 || a_multi !== 1'b1) $display("FAIL mid_flags got any=%0b multi=%0b exp 1/1", a_any, a_multi); else pass_cnt++;
      total_cnt++; if (a_err !== 1'b1) $display("FAIL mid_err got=%0b exp=1", a_err); else pass_cnt++;
      #2;
      rst = 1'b1;
      #1;
      total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL async_rst_out_valid got=%0b exp=0", a_out_valid); else pass_cnt++;
      total_cnt++; if (a_code !== 3'd0) $display("FAIL async_rst_code got=%0d exp=0", a_code); else pass_cnt++;
      total_cnt++; if (a_any !== 1'b0 || a_multi !== 1'b0) $display("FAIL async_rst_flags got any=%0b multi=%0b exp 0/0", a_any, a_multi); else pass_cnt++;
      total_cnt++; if (a_err !== 1'b0) $display("FAIL async_rst_err got=%0b exp=0", a_err); else pass_cnt++;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_one_hot_sweep();
      b_out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         b_in_valid = 1'b1;
         b_req      = 8'(1 << k);
         total_cnt++; if (b_in_ready !== 1'b1) $display("FAIL sweep_in_ready k=%0d got=%0b exp=1", k, b_in_ready); else pass_cnt++;
         step();
         total_cnt++; if (b_out_valid !== 1'b1) $display("FAIL sweep_out_valid k=%0d got=%0b exp=1", k, b_out_valid); else pass_cnt++;
         total_cnt++; if (b_code !== 3'(k)) $display("FAIL sweep_code k=%0d got=%0d exp=%0d", k, b_code, k); else pass_cnt++;
         total_cnt++; if (b_multi !== 1'b0 || b_any !== 1'b1) $display("FAIL sweep_flags k=%0d got any=%0b multi=%0b exp 1/0", k, b_any, b_multi); else pass_cnt++;
      end
      b_in_valid = 1'b0;
      step();
      total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL sweep_drain_valid got=%0b exp=0", b_out_valid); else pass_cnt++;
      total_cnt++; if (b_code !== 3'd7) $display("FAIL sweep_drain_hold got=%0d exp=7", b_code); else pass_cnt++;
      total_cnt++; if (b_err !== 1'b0) $display("FAIL sweep_err got=%0b exp=0", b_err); else pass_cnt++;
   endtask

   task automatic test_stall();
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_req       = 8'h80;
      step();
      a_req = 8'h01;
      for (int s = 0; s < 3; s++) begin
         total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL stall_in_ready s=%0d got=%0b exp=0", s, a_in_ready); else pass_cnt++;
         total_cnt++; if (a_code !== 3'd7) $display("FAIL stall_code s=%0d got=%0d exp=7", s, a_code); else pass_cnt++;
         total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL stall_out_valid s=%0d got=%0b exp=1", s, a_out_valid); else pass_cnt++;
         step();
      end
      a_out_ready = 1'b1;
      #1;
      total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL stall_release_in_ready got=%0b exp=1", a_in_ready); else pass_cnt++;
      step();
      a_in_valid = 1'b0;
      total_cnt++; if (a_code !== 3'd0 || a_out_valid !== 1'b1) $display("FAIL stall_next_code got=%0d valid=%0b exp 0/1", a_code, a_out_valid); else pass_cnt++;
      step();
      total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL stall_drain got=%0b exp=0", a_out_valid); else pass_cnt++;
   endtask

   task automatic test_zero_hot();
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_req       = 8'h40;
      step();
      total_cnt++; if (a_code !== 3'd6) $display("FAIL zero_pre_code got=%0d exp=6", a_code); else pass_cnt++;
      a_req = 8'h00;
      step();
      a_in_valid = 1'b0;
      total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL zero_out_valid got=%0b exp=1", a_out_valid); else pass_cnt++;
      total_cnt++; if (a_code !== 3'd0) $display("FAIL zero_code got=%0d exp=0", a_code); else pass_cnt++;
      total_cnt++; if (a_any !== 1'b0 || a_multi !== 1'b0) $display("FAIL zero_flags got any=%0b multi=%0b exp 0/0", a_any, a_multi); else pass_cnt++;
      total_cnt++; if (a_err !== 1'b0) $display("FAIL zero_err got=%0b exp=0", a_err); else pass_cnt++;
      step();
   endtask

   task automatic test_sticky();
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_req       = 8'h0C;
      step();
      total_cnt++; if (a_err !== 1'b1 || a_multi !== 1'b1) $display("FAIL sticky_set got err=%0b multi=%0b exp 1/1", a_err, a_multi); else pass_cnt++;
`ifndef PRIO_ENC_ROUND_ROBIN_EN
      total_cnt++; if (a_code !== 3'd2) $display("FAIL sticky_code got=%0d exp=2", a_code); else pass_cnt++;
`endif
      a_req = 8'h00;
      step();
      a_in_valid = 1'b0;
      total_cnt++; if (a_err !== 1'b1 || a_any !== 1'b0) $display("FAIL sticky_hold got err=%0b any=%0b exp 1/0", a_err, a_any); else pass_cnt++;
      step();
      step();
      total_cnt++; if (a_err !== 1'b1) $display("FAIL sticky_idle got=%0b exp=1", a_err); else pass_cnt++;
   endtask

`ifndef PRIO_ENC_ROUND_ROBIN_EN
   task automatic test_fixed_multi();
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_req       = 8'b0010_1000;
      step();
      total_cnt++; if (b_code !== 3'd5 || b_multi !== 1'b1) $display("FAIL msb_multi got code=%0d multi=%0b exp 5/1", b_code, b_multi); else pass_cnt++;
      b_req = 8'hFF;
      step();
      b_in_valid = 1'b0;
      total_cnt++; if (b_code !== 3'd7) $display("FAIL msb_all got=%0d exp=7", b_code); else pass_cnt++;
      a_in_valid = 1'b1;
      a_req      = 8'hF0;
      step();
      a_in_valid = 1'b0;
      total_cnt++; if (a_code !== 3'd4) $display("FAIL lsb_multi got=%0d exp=4", a_code); else pass_cnt++;
      step();
   endtask
`endif

   task automatic test_n2();
      c_out_ready = 1'b1;
      c_in_valid  = 1'b1;
      c_req       = 2'b11;
      step();
      total_cnt++; if (c_code !== 1'b0) $display("FAIL n2_code got=%0d exp=0", c_code); else pass_cnt++;
      total_cnt++; if (c_multi !== 1'b1 || c_any !== 1'b1) $display("FAIL n2_flags got any=%0b multi=%0b exp 1/1", c_any, c_multi); else pass_cnt++;
      c_req = 2'b10;
      step();
      c_in_valid = 1'b0;
      total_cnt++; if (c_code !== 1'b1 || c_multi !== 1'b0) $display("FAIL n2_hi got code=%0d multi=%0b exp 1/0", c_code, c_multi); else pass_cnt++;
      step();
   endtask

`ifdef PRIO_ENC_ROUND_ROBIN_EN
   task automatic test_round_robin();
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      d_out_ready = 1'b1;
      d_in_valid  = 1'b1;
      d_req       = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         total_cnt++; if (d_code !== exp_seq[i]) $display("FAIL rr_seq i=%0d got=%0d exp=%0d", i, d_code, exp_seq[i]); else pass_cnt++;
      end
      d_req = 4'b0100;
      step();
      total_cnt++; if (d_code !== 2'd2) $display("FAIL rr_ptr1 got=%0d exp=2", d_code); else pass_cnt++;
      d_req = 4'b0011;
      step();
      d_in_valid = 1'b0;
      total_cnt++; if (d_code !== 2'd0) $display("FAIL rr_wrap got=%0d exp=0", d_code); else pass_cnt++;
      step();
   endtask
`endif

   initial begin
      pass_cnt    = 0;
      total_cnt   = 0;
      rst         = 1'b1;
      a_in_valid  = 1'b0; a_req = '0; a_out_ready = 1'b0;
      b_in_valid  = 1'b0; b_req = '0; b_out_ready = 1'b0;
      c_in_valid  = 1'b0; c_req = '0; c_out_ready = 1'b0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      d_in_valid  = 1'b0; d_req = '0; d_out_ready = 1'b0;
`endif
      #2;
      test_reset();
      test_one_hot_sweep();
      test_stall();
      test_zero_hot();
      test_sticky();
`ifndef PRIO_ENC_ROUND_ROBIN_EN
      test_fixed_multi();
`endif
      test_n2();
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      test_round_robin();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
